crosshair_cursor: RTL and testbench

Parametrised mouse-driven crosshair renderer for the VGA pipeline. Accumulates relative mouse motion between frames, applies it once per frame with screen-edge clamping, and reports per-pixel cursor membership to the colour mapper. Also emits a one-cycle shot pulse on trigger press, and can flash a solid box for a configurable number of frames after each shot. Successor to the fixed-size keycode-driven cursor.

---
 rtl/crosshair_cursor.sv | 115 +++++++++++
 tb/tb_crosshair_cursor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/crosshair_cursor.sv
// crosshair_cursor: mouse-driven crosshair with per-frame clamped motion and shot pulse.
// Define CROSSHAIR_FLASH_EN to flash a solid box for FLASH_FRAMES frames after each shot.
module crosshair_cursor #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int CURSOR_SIZE  = 16,
  parameter int ARM_WIDTH    = 2,
  parameter int FLASH_FRAMES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       mouse_valid,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic       mouse_btn,
  output logic       is_cursor,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       shot_pulse
);
  localparam logic [9:0]  X_MAX = 10'(H_RES - CURSOR_SIZE);
  localparam logic [9:0]  Y_MAX = 10'(V_RES - CURSOR_SIZE);
  localparam logic [9:0]  X0    = 10'((H_RES - CURSOR_SIZE) / 2);
  localparam logic [9:0]  Y0    = 10'((V_RES - CURSOR_SIZE) / 2);
  localparam logic [10:0] SZ    = 11'(CURSOR_SIZE);
  localparam logic [10:0] LO    = 11'(CURSOR_SIZE / 2 - ARM_WIDTH / 2);
  localparam logic [10:0] HI    = 11'(CURSOR_SIZE / 2 + ARM_WIDTH / 2 - 1);

  logic [11:0] acc_x, acc_y;
  logic        frame_s, frame_p, frame_edge, btn_q, flashing, in_box, arm;
  logic [10:0] rel_x, rel_y;

  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [8:0] d);
    logic [12:0] s;
    s = {a[11], a} + {{4{d[8]}}, d};
    return (s[12] ^ s[11]) ? (s[12] ? 12'h800 : 12'h7ff) : s[11:0];
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] p, input logic [11:0] a, input logic [9:0] mx);
    logic [12:0] s;
    s = {3'b000, p} + {a[11], a};
    return s[12] ? 10'd0 : (s > {3'b000, mx}) ? mx : s[9:0];
  endfunction

  assign frame_edge = frame_s & ~frame_p;
  assign rel_x      = {1'b0, DrawX} - {1'b0, cursor_x};
  assign rel_y      = {1'b0, DrawY} - {1'b0, cursor_y};
  assign in_box     = ~rel_x[10] & ~rel_y[10] & (rel_x < SZ) & (rel_y < SZ);
  assign arm        = (rel_x >= LO && rel_x <= HI) || (rel_y >= LO && rel_y <= HI);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_s    <= 1'b0;
      frame_p    <= 1'b0;
      cursor_x   <= X0;
      cursor_y   <= Y0;
      acc_x      <= '0;
      acc_y      <= '0;
      btn_q      <= 1'b0;
      shot_pulse <= 1'b0;
      is_cursor  <= 1'b0;
    end else begin
      frame_s    <= frame_clk;
      frame_p    <= frame_s;
      // a delta arriving on the edge cycle belongs to the next frame
      if (frame_edge) begin
        cursor_x <= clamp(cursor_x, acc_x, X_MAX);
        cursor_y <= clamp(cursor_y, acc_y, Y_MAX);
        acc_x    <= mouse_valid ? {{3{mouse_dx[8]}}, mouse_dx} : '0;
        acc_y    <= mouse_valid ? {{3{mouse_dy[8]}}, mouse_dy} : '0;
      end else if (mouse_valid) begin
        acc_x <= sat_add(acc_x, mouse_dx);
        acc_y <= sat_add(acc_y, mouse_dy);
      end
      if (mouse_valid) btn_q <= mouse_btn;
      shot_pulse <= mouse_valid & mouse_btn & ~btn_q;
      is_cursor  <= in_box & (arm | flashing);
    end
  end

`ifdef CROSSHAIR_FLASH_EN
  typedef enum logic {IDLE, FLASH} state_t;
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (shot_pulse) begin
      state_n = FLASH;
      cnt_n   = 4'(FLASH_FRAMES);
    end else if (state == FLASH && frame_edge) begin
      cnt_n   = cnt - 4'd1;
      state_n = (cnt == 4'd1) ? IDLE : FLASH;
    end
  end

  assign flashing = (state == FLASH);
`else
  assign flashing = 1'b0;
`endif
endmodule

// File: tb/tb_crosshair_cursor.sv
// tb_crosshair_cursor: directed vectors with a queued scoreboard and a negedge monitor.
module tb_crosshair_cursor;
  logic       Clk = 0, Reset = 1, frame_clk = 0, mouse_valid = 0, mouse_btn = 0;
  logic [9:0] DrawX = 0, DrawY = 0;
  logic [8:0] mouse_dx = 0, mouse_dy = 0;
  logic       is_cursor, shot_pulse;
  logic [9:0] cursor_x, cursor_y;

`ifdef CROSSHAIR_FLASH_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  crosshair_cursor dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
    .mouse_valid(mouse_valid), .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_btn(mouse_btn),
    .is_cursor(is_cursor), .cursor_x(cursor_x), .cursor_y(cursor_y), .shot_pulse(shot_pulse)
  );

  always #10 Clk = ~Clk;

  typedef struct {int kind; int want; int due;} exp_t;
  exp_t  q[$];
  int    cyc = 0, n_vec = 0, n_bad = 0;
  string names[4] = '{"cursor_x", "cursor_y", "is_cursor", "shot_pulse"};

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int act(input int k);
    return k == 0 ? int'(cursor_x) : k == 1 ? int'(cursor_y) : k == 2 ? int'(is_cursor) : int'(shot_pulse);
  endfunction

  always @(negedge Clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due <= cyc) begin
        n_vec++;
        if (act(q[i].kind) != q[i].want) begin
          n_bad++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", names[q[i].kind], cyc, act(q[i].kind), q[i].want);
        end
        q.delete(i);
      end

  task automatic exp_at(input int k, input int w, input int lat);
    q.push_back('{k, w, cyc + lat});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic chk(input int k, input int w);
    exp_at(k, w, 1);
    step(1);
  endtask

  task automatic pix(input int x, input int y, input int w);
    DrawX = 10'(x);
    DrawY = 10'(y);
    chk(2, w);
  endtask

  task automatic mv(input int dx, input int dy, input bit b, input int shot);
    mouse_valid = 1;
    mouse_dx    = 9'(dx);
    mouse_dy    = 9'(dy);
    mouse_btn   = b;
    exp_at(3, shot, 1);
    step(1);
    mouse_valid = 0;
  endtask

  // optional delta lands exactly on the edge-detect cycle
  task automatic frame(input int ex, input int ey, input bit sv = 0, input int sdx = 0);
    frame_clk = 1;
    exp_at(0, ex, 2);
    exp_at(1, ey, 2);
    step(1);
    frame_clk = 0;
    if (sv) begin
      mouse_valid = 1;
      mouse_dx    = 9'(sdx);
      mouse_dy    = 0;
    end
    step(1);
    mouse_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    step(1);
    chk(0, 312); chk(1, 232); chk(2, 0); chk(3, 0);
    Reset = 0;
    pix(320, 232, 1); pix(312, 232, 0); pix(312, 240, 1); pix(319, 232, 1);
    pix(321, 232, 0); pix(327, 240, 1); pix(328, 240, 0);
    repeat (3) mv(10, 0, 0, 0);
    frame(342, 232);
    frame(342, 232);
    repeat (2) mv(-255, 255, 0, 0);
    frame(0, 464);
    mv(20, 0, 0, 0);
    frame(20, 464, 1, 5);
    frame(25, 464);
    repeat (3) mv(255, -255, 0, 0);
    frame(624, 0);
    repeat (9) mv(-255, 0, 0, 0);
    frame(0, 0);
    pix(5, 8, 1); pix(16, 8, 0); pix(6, 6, 0); pix(8, 15, 1);
    Reset = 1;
    chk(0, 312);
    Reset = 0;
    chk(1, 232);
    DrawX = 312;
    DrawY = 232;
    mv(0, 0, 1, 1);
    repeat (5) mv(0, 0, 1, 0);
    chk(2, FL); chk(3, 0);
    for (int i = 0; i < 3; i++) begin
      frame(312, 232);
      chk(2, FL);
    end
    frame(312, 232);
    chk(2, 0);
    mv(8, 0, 0, 0);
    frame(320, 232);
    mv(0, 0, 1, 1);
    step(2);
    pix(320, 232, FL);
    mv(100, 0, 1, 0);
    Reset = 1;
    chk(0, 312);
    Reset = 0;
    chk(1, 232);
    pix(312, 232, 0);
    frame(312, 232);
    mv(0, 0, 1, 1);
    step(3);
    if (q.size() != 0) begin
      $display("FAIL pending %0d expectations never checked", q.size());
      n_bad += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
